// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encoding and operand signedness decode.
package mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Returns {a_signed, b_signed} for an opcode.
    function automatic logic [1:0] operand_signed(input logic [2:0] f3);
        logic [1:0] sgn;
        case (f3)
            F3_MULH:   sgn = 2'b11;
            F3_MULHSU: sgn = 2'b10;
            F3_DIV:    sgn = 2'b11;
            F3_REM:    sgn = 2'b11;
            default:   sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the core control FSM (master) and the MDU (slave).
interface mdu_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, a, b, input busy, done, result);
    modport slave  (input start, funct3, a, b, output busy, done, result);
endinterface

// File: rtl/mdu_divider.sv
// Restoring shift-subtract divider kernel on unsigned magnitudes, one quotient
// bit per step. The *_nxt outputs expose the post-step values so the caller can
// finish on the last step without an extra cycle.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;

    // Trial subtraction and next-state selection.
    always_comb begin
        shifted_s = {rem_q, quo_q[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dsr_q};
        if (!diff_s[XLEN]) begin
            rem_nxt = diff_s[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = shifted_s[XLEN-1:0];
            quo_nxt = {quo_q[XLEN-2:0], 1'b0};
        end
        if (load) begin
            quo_d = dividend;
            rem_d = {XLEN{1'b0}};
            dsr_d = divisor;
        end else if (step) begin
            quo_d = quo_nxt;
            rem_d = rem_nxt;
            dsr_d = dsr_q;
        end else begin
            quo_d = quo_q;
            rem_d = rem_q;
            dsr_d = dsr_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= {XLEN{1'b0}};
            rem_q <= {XLEN{1'b0}};
            dsr_q <= {XLEN{1'b0}};
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MDU_DIV_EN to build the divider; otherwise divide opcodes return 0 in one cycle.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic [1:0]        sgn_s;
    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN:0]     mul_add_s, mul_sum_s;
    logic [2*XLEN-1:0] prod_nxt_s, prod_fin_s;

`ifdef MDU_DIV_EN
    logic              div_load_s, div_step_s;
    logic [XLEN-1:0]   quo_nxt_s, rem_nxt_s, div_pick_s;

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load_s),
        .step     (div_step_s),
        .dividend (mag_a_s),
        .divisor  (mag_b_s),
        .quo_nxt  (quo_nxt_s),
        .rem_nxt  (rem_nxt_s)
    );
`endif

    // Next-state, multiply step and result formation.
    always_comb begin
        sgn_s      = operand_signed(bus.funct3);
        a_neg_s    = sgn_s[1] & bus.a[XLEN-1];
        b_neg_s    = sgn_s[0] & bus.b[XLEN-1];
        mag_a_s    = a_neg_s ? -bus.a : bus.a;
        mag_b_s    = b_neg_s ? -bus.b : bus.b;
        mul_add_s  = prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}};
        mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} + mul_add_s;
        prod_nxt_s = {mul_sum_s, prod_q[XLEN-1:1]};
        prod_fin_s = neg_q ? -prod_nxt_s : prod_nxt_s;

        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        res_d   = res_q;
`ifdef MDU_DIV_EN
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        div_pick_s = f3_q[1] ? rem_nxt_s : quo_nxt_s;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    f3_d  = bus.funct3;
                    cnt_d = CW'(XLEN);
                    if (!bus.funct3[2]) begin
                        state_d = S_MUL;
                        neg_d   = a_neg_s ^ b_neg_s;
                        prod_d  = {{XLEN{1'b0}}, mag_a_s};
                        mcand_d = mag_b_s;
`ifdef MDU_DIV_EN
                    end else if (bus.b != {XLEN{1'b0}}) begin
                        state_d    = S_DIV;
                        // Remainder takes the dividend's sign, quotient the XOR.
                        neg_d      = bus.funct3[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                        div_load_s = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = {CW{1'b0}};
                        res_d   = bus.funct3[1] ? bus.a : {XLEN{1'b1}};
                    end
`else
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = {CW{1'b0}};
                        res_d   = {XLEN{1'b0}};
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                prod_d = prod_nxt_s;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    res_d   = (f3_q == F3_MUL) ? prod_fin_s[XLEN-1:0] : prod_fin_s[2*XLEN-1:XLEN];
                end else begin
                    state_d = S_MUL;
                end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                div_step_s = 1'b1;
                cnt_d      = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    res_d   = neg_q ? -div_pick_s : div_pick_s;
                end else begin
                    state_d = S_DIV;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            f3_q    <= 3'b000;
            neg_q   <= 1'b0;
            mcand_q <= {XLEN{1'b0}};
            prod_q  <= {(2*XLEN){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed vector table, random ops
// against a behavioural reference, extra-start noise and mid-operation reset.
module tb_mdu_iterative;
    import mdu_pkg::*;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 100;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    logic [31:0] exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    mdu_if #(.XLEN(XLEN)) bus ();

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic [63:0]        up;
        logic signed [31:0] x, y;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        x  = a;
        y  = b;
        r  = 32'd0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else r = x / y;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else r = x % y;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
`ifndef MDU_DIV_EN
        if (f3[2]) r = 32'd0;
`endif
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] b);
`ifdef MDU_DIV_EN
        return (f3[2] && b == 32'd0) ? 1 : XLEN + 1;
`else
        return f3[2] ? 1 : XLEN + 1;
`endif
    endfunction

    task automatic add_vec(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.res = res; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Issue one operation, wait (bounded) for done, score result, latency and busy span.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit noise);
        int lat;
        int busy_cycles;
        logic [31:0] want;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.a      = a;
        bus.b      = b;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.a      = $urandom;
        bus.b      = $urandom;
        bus.funct3 = 3'($urandom_range(0, 7));
        lat = 1;
        busy_cycles = 0;
        while (!bus.done && lat < MAX_WAIT) begin
            if (bus.busy) busy_cycles++;
            if (noise && lat > 2 && lat < 20) begin
                bus.start  = lat[0];
                bus.a      = $urandom;
                bus.b      = $urandom;
                bus.funct3 = 3'($urandom_range(0, 7));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy) busy_cycles++;
        check({name, " done seen"}, bus.done, 1'b1);
        want = exp_q.pop_front();
        if (bus.done) begin
            check({name, " result"}, bus.result, want);
            check({name, " latency"}, lat, exp_lat);
            check({name, " busy cycles"}, busy_cycles, exp_lat);
        end
        @(posedge clk);
        #1;
        check({name, " done pulse ends"}, bus.done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int no_done;
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a      = 32'd0;
        bus.b      = 32'd0;

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        add_vec("MUL 7*-3",         F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        add_vec("MULH min*min",     F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
        add_vec("MULHU max*max",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        add_vec("MULHSU -1*2",      F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        add_vec("DIV -7/2",         F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        add_vec("REM -7/2",         F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        add_vec("DIVU 100/7",       F3_DIVU,   32'd100,      32'd7,        32'd14,       33);
        add_vec("REMU 100/7",       F3_REMU,   32'd100,      32'd7,        32'd2,        33);
        add_vec("DIV 5/0",          F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        add_vec("REM 5/0",          F3_REM,    32'd5,        32'd0,        32'd5,        1);
        add_vec("DIV ovf",          F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        add_vec("REM ovf",          F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
        add_vec("DIVU 9/3",         F3_DIVU,   32'd9,        32'd3,        32'd3,        33);
`ifndef MDU_DIV_EN
        foreach (vecs[i]) begin
            if (vecs[i].f3[2]) begin
                vecs[i].res = 32'd0;
                vecs[i].lat = 1;
            end
        end
`endif
        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0);

        for (int i = 0; i < 10; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 4 == 0) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d f3=%0d", i, rf3), rf3, ra, rb,
                   ref_result(rf3, ra, rb), ref_lat(rf3, rb), 1'b0);
        end

        run_op("MULHU noisy start", F3_MULHU, 32'h12345678, 32'h9ABCDEF0,
               ref_result(F3_MULHU, 32'h12345678, 32'h9ABCDEF0), XLEN + 1, 1'b1);
        run_op("REM noisy start", F3_REM, 32'hFFFF1234, 32'd77,
               ref_result(F3_REM, 32'hFFFF1234, 32'd77), ref_lat(F3_REM, 32'd77), 1'b1);

        // Mid-operation asynchronous reset.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = F3_MUL;
        bus.a      = 32'd1000;
        bus.b      = 32'd1000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        check("pre-reset busy", bus.busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async reset busy", bus.busy, 1'b0);
        check("async reset done", bus.done, 1'b0);
        check("async reset result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        no_done = 1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) no_done = 0;
        end
        check("no done after abort", no_done, 1);
        run_op("MUL 3*4 after reset", F3_MUL, 32'd3, 32'd4, 32'd12, XLEN + 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative integer multiply/divide unit for the multicycle RISC-V core, implementing the RV32M operations with a parametrised word width. It sits beside the main ALU: the control FSM issues an operation with `start`, stalls while `busy` is high, and writes `result` back through the result mux when `done` pulses. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract, one bit per cycle.

## Interface
- `XLEN`, default 32: operand/result width; legal values are any even number ≥ 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  operand rs1; captured when `start` is accepted.
- `b`  in  XLEN  operand rs2; captured when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle.
- `done`  out  1  single-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  last completed result; held until the next `done`.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → MUL when `start` is high and `funct3[2]`=0.
  - IDLE → DIV when `start` is high, `funct3[2]`=1 and `b`≠0.
  - IDLE → DONE when `start` is high, `funct3[2]`=1 and `b`=0 (divide-by-zero fast path).
  - MUL/DIV → DONE after XLEN iterations; DONE → IDLE unconditionally.
- On acceptance, capture `funct3`, the operand magnitudes and the result sign. Load the iteration counter with XLEN.
- Signedness: operand a is signed for MULH, MULHSU, DIV and REM. Operand b is signed for MULH, DIV and REM.
- Signed operations compute on magnitudes and negate at the end when the sign requires it. Negating the 2·XLEN product or the XLEN quotient/remainder is done in the DONE transition.
- MUL returns the low XLEN bits of the product. MULH/MULHSU/MULHU return the high XLEN bits.
- Divide by zero: DIV/DIVU result is all-ones; REM/REMU result is `a`.
- Signed overflow (a = −2^(XLEN−1), b = −1): DIV result is −2^(XLEN−1); REM result is 0.
- Remainder sign follows the dividend.
- `start` in any state other than IDLE is ignored; the operands are not re-captured.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, internal accumulators 0.
- If `start` is accepted at edge k:
  - `busy`=1 from cycle k+1.
  - Iterations run in cycles k+1 … k+XLEN.
  - `done`=1 and `result` is valid in cycle k+XLEN+1 (latency XLEN+1 cycles).
  - `busy` falls at k+XLEN+2.
- Divide-by-zero fast path: `done` is asserted in cycle k+1 (latency 1 cycle).
- Back-to-back: `start` is acceptable in the cycle after DONE. No start is accepted in the DONE cycle itself.
- `rst` asserted mid-operation immediately aborts to IDLE and clears all outputs; no `done` is produced.
- `a`, `b` and `funct3` may change freely after acceptance.

## Configuration
- `MDU_DIV_EN` defined: full behaviour as above.
- `MDU_DIV_EN` undefined:
  - The DIV state and the divider datapath are removed.
  - Any `funct3[2]`=1 request takes the fast path: `done` in cycle k+1 with `result`=0.
  - Multiply behaviour and timing are unchanged.

## Structure
- `mdu_pkg` holds:
  - the funct3 opcode localparams;
  - the FSM state enum typedef;
  - a function returning the (a_signed, b_signed) pair for a given funct3.
- One sub-module, `mdu_divider`: the restoring shift-subtract kernel with a load/step interface, instantiated only under `MDU_DIV_EN`.
- The multiply kernel stays inline in `mdu_iterative`.

## Test plan
- MUL, XLEN=32, a=7, b=−3 → `result`=0xFFFFFFEB with `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=−1, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Edge cases:
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `done` 1 cycle after start.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same operands → 0.
- Reset mid-operation:
  - Assert `rst` asynchronously in cycle 10 of a MUL → `busy` and `done` go to 0 without waiting for a clock edge, with no `done` pulse.
  - A new MUL 3×4 after release returns 12.
- Extra `start` pulses during busy leave the result unchanged. With `MDU_DIV_EN` undefined, DIVU 9/3 → `result`=0 after 1 cycle.
